// File: rtl/sci_frame_engine_if.sv
// Bus bundle for sci_frame_engine: UART RX/TX, NN core handshake and output-memory read port.
// The slave modport is the engine side; master is the surrounding system.
interface sci_frame_engine_if #(
  parameter int I_BYTES   = 4,
  parameter int D_LEN     = 16,
  parameter int DA_AWIDTH = 8,
  parameter int OFS_WIDTH = 2
);
  logic [7:0]             rx_data;
  logic                   rx_ready;
  logic                   rx_error;
  logic [7:0]             tx_data;
  logic                   tx_ready;
  logic                   tx_start;
  logic                   nn_start;
  logic                   nn_finish;
  logic [I_BYTES*8-1:0]   a_in;
  logic [DA_AWIDTH-1:0]   opm_base;
  logic [OFS_WIDTH-1:0]   opm_offset;
  logic [D_LEN-1:0]       r_data;
  logic                   busy;
  logic                   frame_err;

  modport slave (
    input  rx_data, rx_ready, rx_error, tx_ready, nn_finish, r_data,
    output tx_data, tx_start, nn_start, a_in, opm_base, opm_offset, busy, frame_err
  );

  modport master (
    output rx_data, rx_ready, rx_error, tx_ready, nn_finish, r_data,
    input  tx_data, tx_start, nn_start, a_in, opm_base, opm_offset, busy, frame_err
  );
endinterface

// File: rtl/sci_frame_engine.sv
// Serial frame engine: checksummed RX frames load a_in / pulse nn_start; nn_finish triggers readout and TX.
// Define SCI_TX_FRAME_EN to wrap TX data in SOF + base + checksum framing.
//   RX: IDLE wait SOF_1 | S2/S3 rest of SOF | BASE latch base | LEN check length | PAY shift payload | CHK compare sum
//   RD: IDLE wait nn_finish edge | WAIT read latency | SAMPLE take one neuron, advance address | PACK hand off to TX
//   TX: IDLE wait hand-off | WRDY wait tx_ready | REQ hold tx_start until tx_ready drops | NEXT advance byte
module sci_frame_engine #(
  parameter int         I_BYTES    = 4,
  parameter int         O_BITS     = 32,
  parameter int         D_LEN      = 16,
  parameter int         CELL_N     = 4,
  parameter int         DA_AWIDTH  = 8,
  parameter int         OFS_WIDTH  = 2,
  parameter int         READ_LAT   = 4,
  parameter int         RX_TIMEOUT = 65535,
  parameter logic [7:0] SOF_1      = 8'h55,
  parameter logic [7:0] SOF_2      = 8'hAB,
  parameter logic [7:0] SOF_3      = 8'hAA
) (
  input logic             clk,
  input logic             rst_n,
  sci_frame_engine_if.slave bus
);

  localparam int AW      = I_BYTES * 8;
  localparam int O_BYTES = O_BITS / 8;
`ifdef SCI_TX_FRAME_EN
  localparam int HDR_LEN = 4;
  localparam int TX_LEN  = O_BYTES + 5;
`else
  localparam int HDR_LEN = 0;
  localparam int TX_LEN  = O_BYTES;
`endif
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int BW = $clog2(O_BITS + 1);
  localparam logic [7:0] LEN_B = 8'(I_BYTES);

  typedef enum logic [2:0] {RX_IDLE, RX_S2, RX_S3, RX_BASE, RX_LEN, RX_PAY, RX_CHK} rx_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_SAMPLE, RD_PACK} rd_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WRDY, TX_REQ, TX_NEXT} tx_state_t;

  logic rdy_q1, rdy_q2, fin_q1, fin_q2, err_q;
  logic [7:0] data_q;
  logic byte_ev, fin_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q1 <= 1'b0;
      rdy_q2 <= 1'b0;
      fin_q1 <= 1'b0;
      fin_q2 <= 1'b0;
      err_q  <= 1'b0;
      data_q <= 8'h00;
    end else begin
      rdy_q1 <= bus.rx_ready;
      rdy_q2 <= rdy_q1;
      fin_q1 <= bus.nn_finish;
      fin_q2 <= fin_q1;
      err_q  <= bus.rx_error;
      data_q <= bus.rx_data;
    end
  end

  assign byte_ev = rdy_q1 & ~rdy_q2;
  assign fin_ev  = fin_q1 & ~fin_q2;

  rx_state_t            rx_state;
  logic [AW-1:0]        shadow, a_in_q;
  logic [7:0]           base_new, rx_sum, pay_cnt;
  logic [DA_AWIDTH-1:0] base_commit;
  logic [TW-1:0]        rx_tmr;
  logic                 nn_start_q, frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      shadow      <= '0;
      a_in_q      <= '0;
      base_new    <= 8'h00;
      rx_sum      <= 8'h00;
      pay_cnt     <= 8'h00;
      base_commit <= '0;
      rx_tmr      <= '0;
      nn_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      nn_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (byte_ev) begin
        rx_tmr <= TW'(RX_TIMEOUT);
        if (err_q) begin
          if (rx_state != RX_IDLE) frame_err_q <= 1'b1;
          rx_state <= RX_IDLE;
        end else begin
          case (rx_state)
            RX_IDLE: if (data_q == SOF_1) rx_state <= RX_S2;
            RX_S2:   rx_state <= (data_q == SOF_2) ? RX_S3 : RX_IDLE;
            RX_S3:   rx_state <= (data_q == SOF_3) ? RX_BASE : RX_IDLE;
            RX_BASE: begin
              base_new <= data_q;
              rx_sum   <= data_q;
              rx_state <= RX_LEN;
            end
            RX_LEN: begin
              if (data_q == LEN_B) begin
                rx_sum   <= rx_sum + data_q;
                pay_cnt  <= LEN_B - 8'd1;
                rx_state <= RX_PAY;
              end else begin
                frame_err_q <= 1'b1;
                rx_state    <= RX_IDLE;
              end
            end
            RX_PAY: begin
              shadow <= (shadow << 8) | AW'(data_q);
              rx_sum <= rx_sum + data_q;
              if (pay_cnt == 8'd0) rx_state <= RX_CHK;
              else pay_cnt <= pay_cnt - 8'd1;
            end
            RX_CHK: begin
              // a_in and nn_start update together, one cycle after the checksum byte event
              if (data_q == rx_sum) begin
                a_in_q      <= shadow;
                base_commit <= DA_AWIDTH'(base_new);
                nn_start_q  <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
              rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
          endcase
        end
      end else if (rx_state != RX_IDLE) begin
        if (rx_tmr == '0) begin
          frame_err_q <= 1'b1;
          rx_state    <= RX_IDLE;
        end else begin
          rx_tmr <= rx_tmr - TW'(1);
        end
      end
    end
  end

  rd_state_t            rd_state;
  logic [DA_AWIDTH-1:0] opm_base_q;
  logic [OFS_WIDTH-1:0] opm_ofs_q;
  logic [LW-1:0]        lat_tmr;
  logic [BW-1:0]        bit_cnt;
  logic [O_BITS-1:0]    out_sr;
  logic [D_LEN-1:0]     rd_word;
  logic                 busy_q, tx_go, tx_done;
`ifdef SCI_TX_FRAME_EN
  logic [DA_AWIDTH-1:0] rd_base;
`endif

  assign rd_word = bus.r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state   <= RD_IDLE;
      opm_base_q <= '0;
      opm_ofs_q  <= '0;
      lat_tmr    <= '0;
      bit_cnt    <= '0;
      out_sr     <= '0;
      busy_q     <= 1'b0;
      tx_go      <= 1'b0;
`ifdef SCI_TX_FRAME_EN
      rd_base    <= '0;
`endif
    end else begin
      tx_go <= 1'b0;
      if (tx_done) busy_q <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          // busy covers the whole readout plus transmit, so a repeated edge is dropped here
          if (fin_ev && !busy_q) begin
            opm_base_q <= base_commit;
            opm_ofs_q  <= '0;
            bit_cnt    <= '0;
            lat_tmr    <= LW'(READ_LAT - 1);
            busy_q     <= 1'b1;
`ifdef SCI_TX_FRAME_EN
            rd_base    <= base_commit;
`endif
            rd_state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_tmr == '0) rd_state <= RD_SAMPLE;
          else lat_tmr <= lat_tmr - LW'(1);
        end
        RD_SAMPLE: begin
          out_sr  <= {out_sr[O_BITS-2:0], (rd_word != '0)};
          bit_cnt <= bit_cnt + BW'(1);
          if (opm_ofs_q == OFS_WIDTH'(CELL_N - 1)) begin
            opm_ofs_q  <= '0;
            opm_base_q <= opm_base_q + DA_AWIDTH'(1);
          end else begin
            opm_ofs_q <= opm_ofs_q + OFS_WIDTH'(1);
          end
          if (bit_cnt == BW'(O_BITS - 1)) begin
            rd_state <= RD_PACK;
          end else begin
            lat_tmr  <= LW'(READ_LAT - 1);
            rd_state <= RD_WAIT;
          end
        end
        RD_PACK: begin
          tx_go    <= 1'b1;
          rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  tx_state_t         tx_state;
  logic [O_BITS-1:0] tx_buf;
  logic [7:0]        tx_idx, data_idx, tx_byte, tx_data_q;
  logic              tx_start_q;
`ifdef SCI_TX_FRAME_EN
  logic [7:0]        tx_sum;
`endif

  always_comb begin
    data_idx = tx_idx - 8'(HDR_LEN);
    tx_byte  = 8'(tx_buf >> {data_idx, 3'b000});
`ifdef SCI_TX_FRAME_EN
    tx_sum = 8'(rd_base);
    for (int i = 0; i < O_BYTES; i++) tx_sum = tx_sum + tx_buf[8*i +: 8];
    if (tx_idx == 8'd0)                tx_byte = SOF_1;
    else if (tx_idx == 8'd1)           tx_byte = SOF_2;
    else if (tx_idx == 8'd2)           tx_byte = SOF_3;
    else if (tx_idx == 8'd3)           tx_byte = 8'(rd_base);
    else if (tx_idx == 8'(TX_LEN - 1)) tx_byte = tx_sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      tx_buf     <= '0;
      tx_idx     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_go) begin
            tx_buf   <= out_sr;
            tx_idx   <= 8'h00;
            tx_state <= TX_WRDY;
          end
        end
        TX_WRDY: begin
          if (bus.tx_ready) begin
            tx_data_q  <= tx_byte;
            tx_start_q <= 1'b1;
            tx_state   <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (!bus.tx_ready) begin
            tx_start_q <= 1'b0;
            tx_state   <= TX_NEXT;
          end
        end
        TX_NEXT: begin
          if (tx_idx == 8'(TX_LEN - 1)) begin
            tx_done  <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_idx   <= tx_idx + 8'd1;
            tx_state <= TX_WRDY;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.nn_start   = nn_start_q;
  assign bus.a_in       = a_in_q;
  assign bus.opm_base   = opm_base_q;
  assign bus.opm_offset = opm_ofs_q;
  assign bus.busy       = busy_q;
  assign bus.frame_err  = frame_err_q;

endmodule
